// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   WIDTH_DEF : default operand/result width
//   CNT_W     : bit-counter width for the default width
//   state_t   : control FSM state encoding
//   cnt_width : counter width for an arbitrary operand width
package serial_sub_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/one_bit_subtractor.sv
// One-bit full subtractor cell.
//   x  : minuend bit
//   y  : subtrahend bit
//   bi : borrow in
//   d  : difference bit
//   bo : borrow out
module one_bit_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_sub_16b.sv
// Bit-serial subtractor: d = a - b - bin, one bit per cycle, LSB first.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, bin)
//   out_valid/out_ready : result handshake (d, bout, ovf, zero)
//   fsm_state           : current control state, for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; there
// is no same-cycle path from the result handshake to operand acceptance.
module serial_sub_16b
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output state_t           fsm_state
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;
  logic             bit_d;
  logic             bit_bo;
  logic             last_bit;
  logic [WIDTH-1:0] d_final;

  one_bit_subtractor u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (brw),
    .d  (bit_d),
    .bo (bit_bo)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  // Difference bits are shifted into the vacated top of the minuend register,
  // so on the last bit the full result is the current diff bit over a_sh.
  assign d_final  = {bit_d, a_sh[WIDTH-1:1]};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      brw  <= 1'b0;
      d    <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= d_final;
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          brw  <= bit_bo;
          cnt  <= cnt + 1'b1;
          if (last_bit) begin
            d    <= d_final;
            bout <= bit_bo;
            // On the last bit a_sh[0]/b_sh[0] are the operand sign bits.
            ovf  <= (a_sh[0] ^ b_sh[0]) & (bit_d ^ a_sh[0]);
            zero <= ~|d_final;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_sub_16b.md
SERIAL_SUB_16B -- requirements
Module: serial_sub_16b

Interface
REQ-001 SHALL have parameter: WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operands a, b, bin valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a  input  WIDTH  minuend.
REQ-007 SHALL have port: b  input  WIDTH  subtrahend.
REQ-008 SHALL have port: bin  input  1  borrow-in.
REQ-009 SHALL have port: out_valid  output  1  result fields valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: d  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
REQ-012 SHALL have port: bout  output  1  borrow-out (1 when unsigned a < b + bin).
REQ-013 SHALL have port: ovf  output  1  two's-complement signed overflow.
REQ-014 SHALL have port: zero  output  1  d == 0.

Function
REQ-015 SHALL implement FSM with states IDLE, RUN, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-016 IDLE: in_valid & in_ready at a rising edge SHALL capture a, b into shift registers and bin into the borrow flop, clear the bit counter, and go to RUN; in_valid SHALL be ignored outside IDLE.
REQ-017 RUN: each cycle SHALL process one bit, LSB first: diff = a0 ^ b0 ^ brw; brw_next = (~a0 & b0) | (~a0 & brw) | (b0 & brw); diff shifted into result MSB; operands shifted right; counter incremented.
REQ-018 RUN SHALL last exactly WIDTH cycles; after the edge processing bit WIDTH-1, the FSM SHALL go to DONE.
REQ-019 Latency: if operands are accepted at edge k, out_valid SHALL first be high in the cycle following edge k+WIDTH (16 cycles for WIDTH=16).
REQ-020 On DONE entry, d, bout, ovf, zero SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-021 ovf SHALL equal (a[MSB] != b[MSB]) & (d[MSB] != a[MSB]), using captured operand MSBs; bin is included in d.
REQ-022 zero SHALL be 1 iff all WIDTH bits of d are 0; bout SHALL be the final borrow flop value.
REQ-023 DONE: out_valid & out_ready at an edge SHALL return to IDLE; in_ready SHALL rise the cycle after, with no same-cycle bypass.
REQ-024 d, bout, ovf, zero SHALL retain last result in IDLE until the next DONE entry.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, counter 0, shift registers 0, borrow flop 0, d=0, bout=0, ovf=0, zero=0, out_valid=0.
REQ-026 in_ready SHALL be 1 whenever state is IDLE, including during reset.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation and discard the result; the first operation after release SHALL be correct.

Structure
REQ-028 Package serial_sub_pkg SHALL hold the WIDTH default, CNT_W = clog2(WIDTH), and the FSM state type.
REQ-029 Sub-module one_bit_subtractor (inputs x, y, bi; outputs d, bo) SHALL implement the REQ-017 bit cell.
REQ-030 Only these SHALL be registered: FSM state, counter, operand shift registers, borrow flop, result register, and flags.

Verification
REQ-031 a=0x0005, b=0x0003, bin=0 -> d=0x0002, bout=0, ovf=0, zero=0; out_valid exactly 16 cycles after acceptance.
REQ-032 a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1, ovf=0; and a=0x0003, b=0x0003, bin=1 -> d=0xFFFF, bout=1.
REQ-033 a=0x8000, b=0x0001 -> d=0x7FFF, ovf=1, bout=0; a=0x1234, b=0x1234 -> d=0x0000, zero=1.
REQ-034 out_ready held low 5 cycles in DONE, with in_valid pulsed -> outputs stable, in_ready=0, new operands not captured; IDLE one edge after out_ready=1.
REQ-035 rst_n low at the 8th RUN cycle -> all outputs 0 and in_ready=1 immediately; next op 0x00FF - 0x0F0F -> d=0xF1F0, bout=1.
REQ-036 Back-to-back operations with in_valid and out_ready held high -> one result per 18 cycles, each matching a reference model.
